// File: rtl/isqrt_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// isqrt_rr_arbiter_if
//   Bundles the requester-side and isqrt-side signals of isqrt_rr_arbiter.
//   Parameter N_REQ : number of requesters.
//   Signals:
//     req_vld[N_REQ]      request valid, one bit per requester
//     req_x[32*N_REQ]     operands, slice i = [32*i +: 32]
//     req_rdy[N_REQ]      one-hot-or-zero grant
//     res_vld[N_REQ]      one-hot-or-zero result strobe
//     res[16]             result value for the flagged requester
//     err                 sticky "result arrived with no tag in flight"
//     isqrt_x_vld/isqrt_x issue strobe and operand to the isqrt unit
//     isqrt_y_vld/isqrt_y result strobe and value from the isqrt unit
//   Modports:
//     slave  : the arbiter itself
//     master : everything around it (requesters plus the isqrt unit)
// ---------------------------------------------------------------------------
interface isqrt_rr_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_vld;
  logic [32*N_REQ-1:0] req_x;
  logic [N_REQ-1:0]    req_rdy;
  logic [N_REQ-1:0]    res_vld;
  logic [15:0]         res;
  logic                err;
  logic                isqrt_x_vld;
  logic [31:0]         isqrt_x;
  logic                isqrt_y_vld;
  logic [15:0]         isqrt_y;

  modport slave (
    input  req_vld, req_x, isqrt_y_vld, isqrt_y,
    output req_rdy, res_vld, res, err, isqrt_x_vld, isqrt_x
  );

  modport master (
    output req_vld, req_x, isqrt_y_vld, isqrt_y,
    input  req_rdy, res_vld, res, err, isqrt_x_vld, isqrt_x
  );
endinterface

// File: rtl/isqrt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// isqrt_rr_arbiter
//   Shares one pipelined, in-order, fixed-latency isqrt unit between N_REQ
//   requesters. A round-robin arbiter admits at most one request per cycle;
//   the granted requester index is pushed into a circular tag FIFO and popped
//   when the matching result comes back, steering the result to its issuer.
//
//   Parameters:
//     N_REQ        number of requesters (2..16)
//     MAX_INFLIGHT tag FIFO depth = max outstanding operations (power of 2)
//   Ports:
//     clk, rst     clock, synchronous active-high reset (shared with isqrt)
//     bus          isqrt_rr_arbiter_if.slave: request/grant, result return,
//                  sticky err, and the isqrt issue/result signals
//   Optional (macro ISQRT_RR_ARBITER_PERF_EN defined):
//     perf_stall   saturating count of cycles with a request but a full FIFO
//     perf_grants  one saturating 32-bit grant counter per requester,
//                  requester i at [32*i +: 32]
// ---------------------------------------------------------------------------
module isqrt_rr_arbiter #(
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  isqrt_rr_arbiter_if.slave    bus
`ifdef ISQRT_RR_ARBITER_PERF_EN
  ,
  output logic [31:0]          perf_stall,
  output logic [32*N_REQ-1:0]  perf_grants
`endif
);

  localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  // Operand slices as an array so the grant index can select one directly.
  logic [31:0] req_x_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign req_x_arr[gi] = bus.req_x[32*gi +: 32];
    end
  endgenerate

  // State
  logic [TAG_W-1:0] rr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [TAG_W-1:0] tag_mem [MAX_INFLIGHT];
  logic [TAG_W-1:0] res_tag_reg;
  logic             res_vld_reg;
  logic [15:0]      res_reg;
  logic             err_reg;

  // Arbitration
  logic             hi_found, lo_found;
  logic [TAG_W-1:0] hi_idx, lo_idx;
  logic             grant_any;
  logic [TAG_W-1:0] grant_idx;
  logic             can_issue;
  logic             issue;
  logic             pop;

  // Round-robin search split in two: the first valid requester at or above
  // rr_ptr wins; if there is none, the search wraps and the lowest valid
  // requester wins. This is the same as scanning rr_ptr, rr_ptr+1, ... mod
  // N_REQ without a modulo adder in the loop.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_vld[i] && !hi_found && (TAG_W'(i) >= rr_ptr_reg)) begin
        hi_found = 1'b1;
        hi_idx   = TAG_W'(i);
      end
      if (bus.req_vld[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = TAG_W'(i);
      end
    end
    grant_any = hi_found | lo_found;
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  // The full check uses the count before this cycle's pop, so a full FIFO
  // never accepts a push even when a result is draining in the same cycle.
  assign can_issue = (count_reg < CNT_W'(MAX_INFLIGHT));
  assign issue     = grant_any & can_issue;
  assign pop       = bus.isqrt_y_vld & (count_reg != '0);

  always_comb begin
    bus.req_rdy = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_rdy[i] = issue && (grant_idx == TAG_W'(i));
    end
  end

  assign bus.isqrt_x_vld = issue;
  assign bus.isqrt_x     = issue ? req_x_arr[grant_idx] : 32'd0;

  // Tag storage: plain array without reset; only the pointers are reset,
  // which is what discards in-flight tags.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[wr_ptr_reg] <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg  <= '0;
      count_reg   <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      res_tag_reg <= '0;
      res_vld_reg <= 1'b0;
      res_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (issue) begin
        rr_ptr_reg <= (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      end

      // Registered read of the tag: the result and its destination appear
      // together one cycle after isqrt_y_vld.
      if (pop) begin
        rd_ptr_reg  <= (rd_ptr_reg == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
        res_tag_reg <= tag_mem[rd_ptr_reg];
        res_reg     <= bus.isqrt_y;
      end
      res_vld_reg <= pop;

      if (bus.isqrt_y_vld && (count_reg == '0)) begin
        err_reg <= 1'b1;
      end

      case ({issue, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_comb begin
    bus.res_vld = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.res_vld[i] = res_vld_reg && (res_tag_reg == TAG_W'(i));
    end
  end

  assign bus.res = res_reg;
  assign bus.err = err_reg;

`ifdef ISQRT_RR_ARBITER_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if ((|bus.req_vld) && !can_issue && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign perf_stall = stall_cnt_reg;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf_grant
      logic [31:0] grant_cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          grant_cnt_reg <= '0;
        end else if (bus.req_rdy[gi] && bus.req_vld[gi] && (grant_cnt_reg != 32'hFFFF_FFFF)) begin
          grant_cnt_reg <= grant_cnt_reg + 32'd1;
        end
      end

      assign perf_grants[32*gi +: 32] = grant_cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_isqrt_rr_arbiter
//   Two arbiter instances, each with its own latency-4 pipelined isqrt model:
//     u0: MAX_INFLIGHT=8 (arbitration, routing, err, mid-operation reset)
//     u1: MAX_INFLIGHT=2 (FIFO-full stalls)
//   A scoreboard queue per instance holds {requester, floor(sqrt(x))} pushed
//   at each handshake and popped on each result strobe.
// ---------------------------------------------------------------------------
module tb_isqrt_rr_arbiter;

  localparam int N   = 4;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inject0 = 1'b0;

  always #5 clk = ~clk;

  isqrt_rr_arbiter_if #(.N_REQ(N)) bus0 ();
  isqrt_rr_arbiter_if #(.N_REQ(N)) bus1 ();

`ifdef ISQRT_RR_ARBITER_PERF_EN
  logic [31:0]    perf_stall0, perf_stall1;
  logic [32*N-1:0] perf_grants0, perf_grants1;
`endif

  isqrt_rr_arbiter #(.N_REQ(N), .MAX_INFLIGHT(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
`ifdef ISQRT_RR_ARBITER_PERF_EN
    ,
    .perf_stall  (perf_stall0),
    .perf_grants (perf_grants0)
`endif
  );

  isqrt_rr_arbiter #(.N_REQ(N), .MAX_INFLIGHT(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
`ifdef ISQRT_RR_ARBITER_PERF_EN
    ,
    .perf_stall  (perf_stall1),
    .perf_grants (perf_grants1)
`endif
  );

  function automatic logic [15:0] fsqrt(input logic [31:0] x);
    logic [63:0] r;
    logic [63:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[15:0];
  endfunction

  // isqrt models: LAT-stage pipelines flushed by the shared reset.
  logic [LAT-1:0] pv0, pv1;
  logic [15:0]    py0 [LAT];
  logic [15:0]    py1 [LAT];

  always @(posedge clk) begin
    if (rst) begin
      pv0 <= '0;
      pv1 <= '0;
    end else begin
      pv0 <= {pv0[LAT-2:0], bus0.isqrt_x_vld};
      pv1 <= {pv1[LAT-2:0], bus1.isqrt_x_vld};
      py0[0] <= fsqrt(bus0.isqrt_x);
      py1[0] <= fsqrt(bus1.isqrt_x);
      for (int k = 1; k < LAT; k++) begin
        py0[k] <= py0[k-1];
        py1[k] <= py1[k-1];
      end
    end
  end

  assign bus0.isqrt_y_vld = pv0[LAT-1] | inject0;
  assign bus0.isqrt_y     = py0[LAT-1];
  assign bus1.isqrt_y_vld = pv1[LAT-1];
  assign bus1.isqrt_y     = py1[LAT-1];

  typedef struct {
    int          idx;
    logic [15:0] y;
  } exp_t;

  exp_t q [2][$];

  int total = 0;
  int bad   = 0;

  logic [N-1:0] gnt  [2];
  logic         got  [2];
  logic [31:0]  xo   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample on the falling edge, run the scoreboard, then return
  // just after the rising edge so the caller can drive the next inputs.
  task automatic step();
    logic [N-1:0]   v, r, rv;
    logic [32*N-1:0] xs;
    logic [15:0]    rs;
    exp_t           e;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      v  = (u == 0) ? bus0.req_vld : bus1.req_vld;
      r  = (u == 0) ? bus0.req_rdy : bus1.req_rdy;
      rv = (u == 0) ? bus0.res_vld : bus1.res_vld;
      xs = (u == 0) ? bus0.req_x   : bus1.req_x;
      rs = (u == 0) ? bus0.res     : bus1.res;
      xo[u]  = (u == 0) ? bus0.isqrt_x : bus1.isqrt_x;
      gnt[u] = v & r;
      got[u] = |rv;
      if (!rst) begin
        if (rv != '0) begin
          if (q[u].size() == 0) begin
            chk($sformatf("u%0d_stray_res_vld", u), 32'(rv), 32'd0);
          end else begin
            e = q[u].pop_front();
            chk($sformatf("u%0d_res_vld", u), 32'(rv), 32'd1 << e.idx);
            chk($sformatf("u%0d_res", u), 32'(rs), 32'(e.y));
            $display("u%0d result req=%0d res=%0d", u, e.idx, rs);
          end
        end
        for (int i = 0; i < N; i++) begin
          if (gnt[u][i]) begin
            e.idx = i;
            e.y   = fsqrt(xs[32*i +: 32]);
            q[u].push_back(e);
            $display("u%0d issue req=%0d x=%0d", u, i, xs[32*i +: 32]);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus0.req_vld = '0;
    bus1.req_vld = '0;
    inject0 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    q[0].delete();
    q[1].delete();
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && (q[0].size() + q[1].size()) != 0; k++) step();
    chk("drain_empty", 32'(q[0].size() + q[1].size()), 32'd0);
    step();
    step();
  endtask

  initial begin
    int          lat;
    int          n;
    int          exp_g [5];
    logic [11:0] pat;

    bus0.req_vld = '0;
    bus0.req_x   = '0;
    bus1.req_vld = '0;
    bus1.req_x   = '0;

    // Reset state
    do_reset();
    do_reset();
    chk("rst_req_rdy", 32'(bus0.req_rdy), 32'd0);
    chk("rst_res_vld", 32'(bus0.res_vld), 32'd0);
    chk("rst_res", 32'(bus0.res), 32'd0);
    chk("rst_err", 32'(bus0.err), 32'd0);
    chk("rst_isqrt_x_vld", 32'(bus0.isqrt_x_vld), 32'd0);

    // Single request, x=144: same-cycle grant, result 5 cycles later
    bus0.req_x[31:0] = 32'd144;
    bus0.req_vld = 4'b0001;
    step();
    chk("t1_grant", 32'(gnt[0]), 32'd1);
    chk("t1_isqrt_x", xo[0], 32'd144);
    bus0.req_vld = '0;
    lat = 0;
    for (int k = 1; k <= 12 && !got[0]; k++) begin
      step();
      lat = k;
    end
    chk("t1_latency", 32'(lat), 32'd5);
    chk("t1_res_value", 32'(bus0.res), 32'd12);
    drain();

    // All four held, x=i*i+1: grants 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) bus0.req_x[32*i +: 32] = 32'(i * i + 1);
    bus0.req_vld = 4'b1111;
    exp_g = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t2_grant%0d", k), 32'(gnt[0]), 32'd1 << exp_g[k]);
    end
    bus0.req_vld = '0;
    drain();

    // rr_ptr=2 with req1 and req3 valid: req3 first, then req1
    do_reset();
    bus0.req_x[32*1 +: 32] = 32'd81;
    bus0.req_x[32*3 +: 32] = 32'd1000;
    bus0.req_vld = 4'b0010;
    step();
    chk("t3_setup_grant", 32'(gnt[0]), 32'b0010);
    bus0.req_x[32*1 +: 32] = 32'd50;
    bus0.req_vld = 4'b1010;
    step();
    chk("t3_first_req3", 32'(gnt[0]), 32'b1000);
    bus0.req_vld = 4'b0010;
    step();
    chk("t3_then_req1", 32'(gnt[0]), 32'b0010);
    bus0.req_vld = '0;
    drain();

    // MAX_INFLIGHT=2 instance, req0 continuous: grants at 0,1,5,6,10,11
    do_reset();
    n = 3;
    bus1.req_x[31:0] = 32'(n * n);
    bus1.req_vld = 4'b0001;
    pat = 12'b1100_0110_0011;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("t4_rdy_c%0d", k), 32'(gnt[1][0]), 32'(pat[k]));
      if (gnt[1][0]) begin
        n++;
        bus1.req_x[31:0] = 32'(n * n + 7);
      end
    end
    bus1.req_vld = '0;
    drain();
`ifdef ISQRT_RR_ARBITER_PERF_EN
    chk("t4_perf_stall", perf_stall1, 32'd6);
    chk("t4_perf_grants0", perf_grants1[31:0], 32'd6);
`endif

    // Result with empty tag FIFO: err sets and sticks, no res_vld
    chk("t5_err_before", 32'(bus0.err), 32'd0);
    inject0 = 1'b1;
    step();
    inject0 = 1'b0;
    chk("t5_err_set", 32'(bus0.err), 32'd1);
    chk("t5_res_vld", 32'(bus0.res_vld), 32'd0);
    step();
    step();
    chk("t5_err_sticky", 32'(bus0.err), 32'd1);

    // Reset with three operations in flight
    do_reset();
    for (int i = 0; i < N; i++) bus0.req_x[32*i +: 32] = 32'(100 + i);
    bus0.req_vld = 4'b0111;
    step();
    step();
    step();
    chk("t6_inflight", 32'(q[0].size()), 32'd3);
    bus0.req_vld = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q[0].delete();
    chk("t6_rst_res_vld", 32'(bus0.res_vld), 32'd0);
    chk("t6_rst_res", 32'(bus0.res), 32'd0);
    chk("t6_rst_err", 32'(bus0.err), 32'd0);
    chk("t6_rst_rdy", 32'(bus0.req_rdy), 32'd0);
    for (int k = 0; k < 8; k++) step();
    bus0.req_x[32*2 +: 32] = 32'd49;
    bus0.req_vld = 4'b0100;
    step();
    chk("t6_new_grant", 32'(gnt[0]), 32'b0100);
    bus0.req_vld = '0;
    drain();
    chk("t6_new_res", 32'(bus0.res), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
